// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// FSM states, owner tags and default bus widths.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_GNT = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection for the memory port arbiter.
// Data wins unless fetch has waited STARVE_MAX data issues.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic if_flush_i,
  input  logic d_req_i,
  output logic pick_vld_o,
  output logic pick_d_o
);

  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          if_ok;
  logic          force_if;

  assign if_ok    = if_req_i & ~if_flush_i;
  assign force_if = if_ok & (starve_q == SMAX);

  assign pick_vld_o = idle_i & (d_req_i | if_ok);
  assign pick_d_o   = d_req_i & ~force_if;

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i) begin
      starve_d = '0;
    end else if (pick_vld_o && !pick_d_o) begin
      starve_d = '0;
    end else if (pick_vld_o && starve_q != SMAX) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store.
// One outstanding transaction; stale fetch responses are dropped.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic                drop_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic idle;
  logic pick_vld;
  logic pick_d;
  logic rsp;
  logic if_flush_own;

  assign idle = (state_q == ARB_IDLE);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_i      (clk),
    .reset_i    (reset),
    .idle_i     (idle),
    .if_req_i   (if_req),
    .if_flush_i (if_flush),
    .d_req_i    (d_req),
    .pick_vld_o (pick_vld),
    .pick_d_o   (pick_d)
  );

  assign rsp          = (state_q == ARB_WAIT_RSP) & mem_rvalid;
  assign if_flush_own = if_flush & (owner_q == OWN_IF);

  // A flush coinciding with the response also kills it.
  assign if_valid = rsp & (owner_q == OWN_IF)
                  & ~drop_q & ~if_flush;
  assign d_valid  = rsp & (owner_q == OWN_D);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  assign stall_if  = if_req & ~if_valid & ~if_flush;
  assign stall_mem = d_req & ~d_valid;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            state_q   <= ARB_WAIT_GNT;
            mem_req_q <= 1'b1;
            if (pick_d) begin
              owner_q     <= OWN_D;
              mem_we_q    <= d_we;
              mem_be_q    <= d_be;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              owner_q     <= OWN_IF;
              mem_we_q    <= 1'b0;
              mem_be_q    <= '1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        ARB_WAIT_GNT: begin
          if (if_flush_own) begin
            drop_q <= 1'b1;
          end
          if (mem_gnt) begin
            state_q   <= ARB_WAIT_RSP;
            mem_req_q <= 1'b0;
          end
        end
        ARB_WAIT_RSP: begin
          if (mem_rvalid) begin
            state_q <= ARB_IDLE;
            drop_q  <= 1'b0;
          end else if (if_flush_own) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          mem_req_q <= 1'b0;
          drop_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
